// File: rtl/cu_pkg.sv
// cu_pkg: shared states, instruction classes, select codes and decode bundles
// for multicycle_control_unit and its instr_decoder.
package cu_pkg;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [1:0] {CLS_ALU = 2'b00, CLS_IMM = 2'b01, CLS_MEM = 2'b10, CLS_BR = 2'b11} cls_t;
    localparam logic [1:0] MUX1_IMM = 2'b00, MUX1_REG = 2'b01, MUX1_MEM = 2'b10;
    localparam logic [1:0] MUX5_ALU = 2'b00, MUX5_MEM = 2'b01, MUX5_IMM = 2'b10;
    localparam logic [1:0] MUX6_NONE = 2'b00, MUX6_CMP = 2'b01, MUX6_REL = 2'b10, MUX6_ZERO = 2'b11;
    localparam logic [2:0] RB_NORM = 3'b000, RB_CMP = 3'b011, RB_NONE = 3'b111;
    // Wide enough for any ALU_W; slice to the opcode width at use.
    localparam logic [31:0] ALU_IDLE = '1;
    typedef struct packed {
        logic [1:0] mux1;
        logic       mux2;
        logic       mux4;
        logic [1:0] mux5;
        logic [1:0] mux6;
        logic [2:0] regs_bank;
    } sel_t;
    // Which states an instruction visits and which strobes it owns.
    typedef struct packed {
        logic has_exec;
        logic has_mem;
        logic has_wb;
        logic is_store;
        logic wb_reg;
        logic flags;
        logic cmp;
    } path_t;
endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: fetch/datapath/memory signals of the control unit.
// slave  - control unit side: takes instr_valid/instr/mem_ready, drives the rest.
// master - fetch/datapath/memory side.
interface multicycle_control_unit_if #(parameter int INSTR_W = 24, parameter int ALU_W = 6);
    logic               instr_valid, instr_ready, mem_ready, ir_load;
    logic [INSTR_W-1:0] instr;
    logic [1:0]         mux1, mux5, mux6;
    logic               mux2, mux4;
    logic [ALU_W-1:0]   alu_op;
    logic [2:0]         regs_bank;
    logic               reg_we, flags_we, mem_we, mem_re, cmp_en, pc_en, busy, mem_err;
    modport slave (
        input  instr_valid, instr, mem_ready,
        output instr_ready, ir_load, mux1, mux2, mux4, mux5, mux6, alu_op, regs_bank,
               reg_we, flags_we, mem_we, mem_re, cmp_en, pc_en, busy, mem_err
    );
    modport master (
        output instr_valid, instr, mem_ready,
        input  instr_ready, ir_load, mux1, mux2, mux4, mux5, mux6, alu_op, regs_bank,
               reg_we, flags_we, mem_we, mem_re, cmp_en, pc_en, busy, mem_err
    );
endinterface

// File: rtl/multicycle_control_unit_instr_decoder.sv
// instr_decoder: combinational map from an instruction word to datapath selects,
// ALU opcode and the state path the instruction takes.
// i_instr  - instruction word
// o_sel    - mux1/2/4/5/6 and regs_bank selects
// o_alu_op - ALU opcode (all-ones when the ALU only passes through)
// o_path   - path descriptor consumed by the control FSM
module instr_decoder import cu_pkg::*; #(
    parameter int INSTR_W = 24,
    parameter int ALU_W   = 6
) (
    input  logic [INSTR_W-1:0] i_instr,
    output sel_t               o_sel,
    output logic [ALU_W-1:0]   o_alu_op,
    output path_t              o_path
);
    cls_t       w_cls;
    logic [2:0] w_sub;
    logic       w_st;
    assign w_cls = cls_t'(i_instr[INSTR_W-1 -: 2]);
    assign w_sub = i_instr[14:12];
    assign w_st  = i_instr[0];
    always_comb begin
        o_sel    = '{mux1: MUX1_IMM, mux2: 1'b0, mux4: 1'b0, mux5: MUX5_ALU, mux6: MUX6_NONE, regs_bank: RB_NORM};
        o_alu_op = ALU_IDLE[ALU_W-1:0];
        o_path   = '0;
        case (w_cls)
            CLS_ALU: begin
                o_sel.mux1  = MUX1_REG;
                o_sel.mux2  = 1'b1;
                o_alu_op    = i_instr[ALU_W+3:4];
                o_path      = '{has_exec: 1'b1, has_mem: 1'b0, has_wb: 1'b1, is_store: 1'b0, wb_reg: 1'b1, flags: 1'b1, cmp: 1'b0};
            end
            CLS_IMM: begin
                o_sel.mux5      = MUX5_IMM;
                o_sel.regs_bank = {1'b0, i_instr[13:12]};
                o_path          = '{has_exec: 1'b0, has_mem: 1'b0, has_wb: 1'b1, is_store: 1'b0, wb_reg: 1'b1, flags: 1'b0, cmp: 1'b0};
            end
            CLS_MEM: begin
                o_sel.mux1      = w_st ? MUX1_REG : MUX1_MEM;
                o_sel.mux2      = 1'b1;
                o_sel.mux4      = 1'b1;
                o_sel.mux5      = MUX5_MEM;
                o_sel.regs_bank = w_st ? RB_NONE : RB_NORM;
                o_path          = '{has_exec: 1'b1, has_mem: 1'b1, has_wb: !w_st, is_store: w_st, wb_reg: !w_st, flags: 1'b0, cmp: 1'b0};
            end
            default: begin
                o_sel.mux6      = (w_sub == 3'b011 || w_sub == 3'b100) ? MUX6_REL : (w_sub == 3'b000) ? MUX6_ZERO : MUX6_CMP;
                o_sel.regs_bank = (w_sub == 3'b011) ? RB_CMP : RB_NONE;
                o_path          = '{has_exec: 1'b1, has_mem: 1'b0, has_wb: 1'b1, is_store: 1'b0, wb_reg: (w_sub == 3'b011), flags: 1'b0, cmp: i_instr[12]};
            end
        endcase
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: sequences one instruction at a time through
// FETCH/DECODE/EXEC/MEM/WB, holding datapath selects for the whole instruction
// and pulsing each write strobe only in the state that owns it.
// clk - rising-edge clock
// rst - asynchronous active-high reset
// bus - slave modport: fetch handshake, memory ready, selects, strobes, status
module multicycle_control_unit import cu_pkg::*; #(
    parameter int INSTR_W     = 24,
    parameter int ALU_W       = 6,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                      clk,
    input logic                      rst,
    multicycle_control_unit_if.slave bus
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    state_t           r_state, w_next;
    sel_t             r_sel, w_sel;
    path_t            r_path, w_path;
    logic [ALU_W-1:0] r_alu_op, w_alu_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_err, w_accept, w_timeout;
    // The instruction is decoded straight off the fetch bus and latched in
    // decoded form, so the selects are already valid during DECODE.
    instr_decoder #(.INSTR_W(INSTR_W), .ALU_W(ALU_W)) u_dec (
        .i_instr (bus.instr),
        .o_sel   (w_sel),
        .o_alu_op(w_alu_op),
        .o_path  (w_path)
    );
    assign w_accept  = (r_state == S_FETCH) && bus.instr_valid;
    // mem_ready in the last allowed cycle still counts as success.
    assign w_timeout = (r_state == S_MEM) && !bus.mem_ready && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_sel     <= '0;
            r_path    <= '0;
            r_alu_op  <= ALU_IDLE[ALU_W-1:0];
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sel    <= w_sel;
                r_path   <= w_path;
                r_alu_op <= w_alu_op;
            end
            r_cnt <= (r_state != S_MEM) ? '0 : bus.mem_ready ? r_cnt : r_cnt + CNT_W'(1);
            if (w_timeout) r_mem_err <= 1'b1;
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = w_accept ? S_DECODE : S_FETCH;
            S_DECODE: w_next = r_path.has_exec ? S_EXEC : S_WB;
            S_EXEC:   w_next = r_path.has_mem ? S_MEM : S_WB;
            S_MEM:    w_next = bus.mem_ready ? (r_path.has_wb ? S_WB : S_FETCH) : w_timeout ? S_HALT : S_MEM;
            S_WB:     w_next = S_FETCH;
            default:  w_next = r_state;
        endcase
    end
    assign bus.instr_ready = (r_state == S_FETCH);
    assign bus.busy        = (r_state != S_FETCH);
    assign bus.ir_load     = w_accept;
    assign {bus.mux1, bus.mux2, bus.mux4, bus.mux5, bus.mux6, bus.regs_bank} = r_sel;
    assign bus.alu_op      = r_alu_op;
    assign bus.flags_we    = (r_state == S_EXEC) && r_path.flags;
    assign bus.cmp_en      = (r_state == S_EXEC) && r_path.cmp;
    assign bus.reg_we      = (r_state == S_WB) && r_path.wb_reg;
    // A store retires from MEM itself, so its pc_en rides on mem_ready.
    assign bus.pc_en       = (r_state == S_WB) || ((r_state == S_MEM) && bus.mem_ready && r_path.is_store);
    assign bus.mem_re      = (r_state == S_MEM) && !r_path.is_store;
    assign bus.mem_we      = (r_state == S_MEM) && r_path.is_store;
    assign bus.mem_err     = r_mem_err;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench; each driven cycle queues the
// expected strobes/selects, a negedge monitor pops and compares them.
module tb_multicycle_control_unit;
    localparam logic [9:0] IRL = 10'h200, FLW = 10'h100, RWE = 10'h080, PCE = 10'h040, MRE = 10'h020;
    localparam logic [9:0] MWE = 10'h010, CMP = 10'h008, RDY = 10'h004, BSY = 10'h002, ERR = 10'h001;
    localparam logic [10:0] SEL_LD = {2'b10, 1'b1, 1'b1, 2'b01, 2'b00, 3'b000};
    localparam logic [10:0] SEL_ST = {2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 3'b111};
    localparam logic [10:0] MSK_MEM = 11'b11_1_1_11_00_111;
    typedef struct {
        string       tag;
        logic [9:0]  st;
        logic [10:0] mask;
        logic [10:0] sel;
        logic [5:0]  alu;
        logic        ac;
    } exp_t;
    logic clk, rst;
    int n_chk = 0, n_bad = 0;
    exp_t q[$];
    logic [10:0] cur_sel = '0, cur_mask = '1;
    logic [5:0]  cur_alu = 6'h3F;
    logic        cur_ac = 1'b1;
    multicycle_control_unit_if #(.INSTR_W(24), .ALU_W(6)) bus ();
    multicycle_control_unit #(.INSTR_W(24), .ALU_W(6), .MEM_TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [9:0] strobes();
        return {bus.ir_load, bus.flags_we, bus.reg_we, bus.pc_en, bus.mem_re, bus.mem_we,
                bus.cmp_en, bus.instr_ready, bus.busy, bus.mem_err};
    endfunction
    function automatic logic [10:0] selv();
        return {bus.mux1, bus.mux2, bus.mux4, bus.mux5, bus.mux6, bus.regs_bank};
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, "_st"}, 32'(strobes()), 32'(e.st));
            chk({e.tag, "_sel"}, 32'(selv() & e.mask), 32'(e.sel & e.mask));
            if (e.ac) chk({e.tag, "_alu"}, 32'(bus.alu_op), 32'(e.alu));
        end
    end
    task automatic cyc(input string tag, input logic v, input logic [23:0] ins, input logic mr, input logic [9:0] st);
        bus.instr_valid = v;
        bus.instr       = ins;
        bus.mem_ready   = mr;
        q.push_back('{tag: tag, st: st, mask: cur_mask, sel: cur_sel, alu: cur_alu, ac: cur_ac});
        @(posedge clk);
        #1;
    endtask
    task automatic acc(input string tag, input logic [23:0] ins, input logic [10:0] sel,
                       input logic [10:0] mask, input logic [5:0] alu, input logic ac);
        cyc({tag, "_acc"}, 1'b1, ins, 1'b0, RDY | IRL);
        cur_sel  = sel;
        cur_mask = mask;
        cur_alu  = alu;
        cur_ac   = ac;
    endtask
    task automatic do_rst();
        bus.instr_valid = 1'b0;
        bus.mem_ready   = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_st", 32'(strobes()), 32'(RDY));
        chk("rst_sel", 32'(selv()), 32'h0);
        chk("rst_alu", 32'(bus.alu_op), 32'h3F);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        cur_sel  = '0;
        cur_mask = '1;
        cur_alu  = 6'h3F;
        cur_ac   = 1'b1;
    endtask
    task automatic mem_op(input string tag, input logic st, input int w, input logic early);
        acc(tag, 24'h800000 | 24'(st), st ? SEL_ST : SEL_LD, MSK_MEM, 6'h3F, 1'b1);
        cyc({tag, "_dec"}, 1'b0, 24'h0, early, BSY);
        cyc({tag, "_ex"}, 1'b0, 24'h0, early, BSY);
        for (int i = 0; i < w; i++) cyc({tag, "_wait"}, 1'b0, 24'h0, 1'b0, BSY | (st ? MWE : MRE));
        cyc({tag, "_mem"}, 1'b0, 24'h0, 1'b1, BSY | (st ? (MWE | PCE) : MRE));
        if (!st) cyc({tag, "_wb"}, 1'b0, 24'h0, 1'b0, BSY | RWE | PCE);
    endtask
    task automatic br(input string tag, input logic [23:0] ins, input logic [1:0] m6,
                      input logic [2:0] rb, input logic ce, input logic rw);
        acc(tag, ins, {6'b0, m6, rb}, 11'b00_0_0_00_11_111, 6'h3F, 1'b0);
        cyc({tag, "_dec"}, 1'b0, 24'h0, 1'b0, BSY);
        cyc({tag, "_ex"}, 1'b0, 24'h0, 1'b0, BSY | (ce ? CMP : 10'h0));
        cyc({tag, "_wb"}, 1'b0, 24'h0, 1'b0, BSY | PCE | (rw ? RWE : 10'h0));
    endtask
    initial begin
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.mem_ready = 1'b0;
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("idle0", 1'b0, 24'h0, 1'b0, RDY);
        cyc("idle1", 1'b0, 24'h0, 1'b1, RDY);
        acc("alu", 24'h0000A0, {2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000}, '1, 6'h0A, 1'b1);
        cyc("alu_dec", 1'b1, 24'h402000, 1'b0, BSY);
        cyc("alu_ex", 1'b1, 24'h402000, 1'b0, BSY | FLW);
        cyc("alu_wb", 1'b0, 24'h0, 1'b0, BSY | RWE | PCE);
        acc("imm", 24'h402000, {2'b00, 1'b0, 1'b0, 2'b10, 2'b00, 3'b010}, 11'b11_1_0_11_00_111, 6'h3F, 1'b1);
        cyc("imm_dec", 1'b0, 24'h0, 1'b0, BSY);
        cyc("imm_wb", 1'b0, 24'h0, 1'b0, BSY | RWE | PCE);
        mem_op("st0", 1'b1, 0, 1'b0);
        mem_op("ld3", 1'b0, 3, 1'b0);
        mem_op("lde", 1'b0, 0, 1'b1);
        mem_op("st2", 1'b1, 2, 1'b0);
        br("br3", 24'hC03000, 2'b10, 3'b011, 1'b1, 1'b1);
        br("br0", 24'hC00000, 2'b11, 3'b111, 1'b0, 1'b0);
        br("br4", 24'hC04000, 2'b10, 3'b111, 1'b0, 1'b0);
        br("br1", 24'hC01000, 2'b01, 3'b111, 1'b1, 1'b0);
        mem_op("ld14", 1'b0, 14, 1'b0);
        cyc("idle2", 1'b0, 24'h0, 1'b0, RDY);
        acc("to", 24'h800000, SEL_LD, MSK_MEM, 6'h3F, 1'b1);
        cyc("to_dec", 1'b0, 24'h0, 1'b0, BSY);
        cyc("to_ex", 1'b0, 24'h0, 1'b0, BSY);
        for (int i = 0; i < 15; i++) cyc("to_mem", 1'b0, 24'h0, 1'b0, BSY | MRE);
        for (int i = 0; i < 3; i++) cyc("to_halt", 1'b1, 24'h402000, 1'b1, BSY | ERR);
        do_rst();
        cyc("post_to", 1'b0, 24'h0, 1'b0, RDY);
        acc("ab", 24'h000550, {2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000}, '1, 6'h15, 1'b1);
        cyc("ab_dec", 1'b0, 24'h0, 1'b0, BSY);
        chk("ab_exec_flags", 32'(bus.flags_we), 32'h1);
        do_rst();
        cyc("post_ab", 1'b0, 24'h0, 1'b0, RDY);
        acc("alu2", 24'h000550, {2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000}, '1, 6'h15, 1'b1);
        cyc("alu2_dec", 1'b0, 24'h0, 1'b0, BSY);
        cyc("alu2_ex", 1'b0, 24'h0, 1'b0, BSY | FLW);
        cyc("alu2_wb", 1'b0, 24'h0, 1'b0, BSY | RWE | PCE);
        cyc("idle3", 1'b0, 24'h0, 1'b0, RDY);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
